// File: rtl/vga_timing_controller.sv
// VGA raster sequencer: pixel-rate divider, H/V counters, syncs and strobes.
// Starts and stops only on frame boundaries under the enable request.
module vga_timing_controller #(
  parameter int N        = 9,
  parameter int CLK_DIV  = 2,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 46,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 18,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic [N:0]   countH,
  output logic [N:0]   countV,
  output logic         hsync,
  output logic         vsync,
  output logic         pixel_tick,
  output logic         active,
  output logic         line_start,
  output logic         frame_start,
  output logic         running
);

  localparam int W       = N + 1;
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HA_LO   = H_SYNC + H_BACK;
  localparam int HA_HI   = HA_LO + H_ACTIVE - 1;
  localparam int VA_LO   = V_SYNC + V_BACK;
  localparam int VA_HI   = VA_LO + V_ACTIVE - 1;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  logic          stop;
  logic [N:0]    next_h;
  logic [N:0]    next_v;

  function automatic logic in_window(
    input logic [N:0] h,
    input logic [N:0] v
  );
    return (h >= W'(HA_LO)) && (h <= W'(HA_HI)) &&
           (v >= W'(VA_LO)) && (v <= W'(VA_HI));
  endfunction

  always_comb begin
    tick   = (div_cnt == DW'(CLK_DIV - 1));
    h_wrap = (countH == W'(H_TOTAL - 1));
    v_wrap = (countV == W'(V_TOTAL - 1));
    stop   = (state == DRAIN) && !enable && h_wrap && v_wrap;
    next_h = h_wrap ? '0 : countH + W'(1);
    next_v = countV;
    if (h_wrap) begin
      next_v = v_wrap ? '0 : countV + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      countH      <= '0;
      countV      <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      unique case (state)
        IDLE: begin
          div_cnt <= '0;
          if (enable) begin
            state       <= RUN;
            running     <= 1'b1;
            countH      <= '0;
            countV      <= '0;
            hsync       <= (H_SYNC == 0);
            vsync       <= (V_SYNC == 0);
            active      <= in_window('0, '0);
            line_start  <= 1'b1;
            frame_start <= 1'b1;
          end
        end
        RUN, DRAIN: begin
          div_cnt <= tick ? '0 : div_cnt + DW'(1);
          state   <= enable ? RUN : DRAIN;
          // Drain completes only on the end-of-frame tick.
          if (tick && stop) begin
            state   <= IDLE;
            running <= 1'b0;
            countH  <= '0;
            countV  <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            active  <= 1'b0;
          end else if (tick) begin
            countH      <= next_h;
            countV      <= next_v;
            hsync       <= (next_h >= W'(H_SYNC));
            vsync       <= (next_v >= W'(V_SYNC));
            active      <= in_window(next_h, next_v);
            pixel_tick  <= 1'b1;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Directed bench for vga_timing_controller on a shrunken 17x9 raster.
// Table vectors for the first frame, hand sequences for drain and reset.
module tb_vga_timing_controller;

  localparam int N  = 9;
  localparam int CD = 2;
  localparam int HT = 17;
  localparam int VT = 9;
  localparam int NV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [N:0] countH;
  logic [N:0] countV;
  logic       hsync;
  logic       vsync;
  logic       pixel_tick;
  logic       active;
  logic       line_start;
  logic       frame_start;
  logic       running;

  vga_timing_controller #(
    .N(N), .CLK_DIV(CD),
    .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_ACTIVE(4), .V_FRONT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .countH(countH),
    .countV(countV),
    .hsync(hsync),
    .vsync(vsync),
    .pixel_tick(pixel_tick),
    .active(active),
    .line_start(line_start),
    .frame_start(frame_start),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int h;
    int v;
    int hs;
    int vs;
    int act;
    int ls;
    int fs;
    int pt;
    int run;
  } vec_t;

  vec_t tbl[NV];
  int checks = 0;
  int failures = 0;
  int cont_bad = 0;
  logic mon_en = 1'b0;
  int ph = 0;
  int pv = 0;
  logic prev_run = 1'b0;

  function automatic logic [26:0] pk(
    input int h, input int v, input int hs, input int vs,
    input int act, input int ls, input int fs, input int pt,
    input int run
  );
    return {10'(h), 10'(v), 1'(hs), 1'(vs), 1'(act),
            1'(ls), 1'(fs), 1'(pt), 1'(run)};
  endfunction

  function automatic logic [26:0] cur();
    return {countH, countV, hsync, vsync, active,
            line_start, frame_start, pixel_tick, running};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [26:0] exp);
    logic [26:0] got;
    got = cur();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got H=%0d V=%0d bits=%b exp H=%0d V=%0d bits=%b",
               nm, got[26:17], got[16:7], got[6:0],
               exp[26:17], exp[16:7], exp[6:0]);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out", nm);
  endtask

  // Counters must advance exactly on pixel_tick and hold otherwise.
  always @(posedge clk) begin
    int eh;
    int ev;
    #1;
    if (mon_en && !rst && running && prev_run) begin
      eh = ph;
      ev = pv;
      if (pixel_tick) begin
        eh = (ph == HT - 1) ? 0 : ph + 1;
        if (ph == HT - 1) ev = (pv == VT - 1) ? 0 : pv + 1;
      end
      if (int'(countH) != eh || int'(countV) != ev) cont_bad++;
    end
    ph = int'(countH);
    pv = int'(countV);
    prev_run = running;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int ls_n, ls_last, ls_bad, fs_n;
    int act_n, hs_low, vs_low, pt_n, max_h, max_v;
    int n, lh, lv, idle_seen;
    logic found;

    tbl[0]  = '{0,   0,  0, 0, 0, 0, 1, 1, 0, 1};
    tbl[1]  = '{1,   0,  0, 0, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{2,   1,  0, 0, 0, 0, 0, 0, 1, 1};
    tbl[3]  = '{7,   3,  0, 0, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{8,   4,  0, 1, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{34,  0,  1, 0, 0, 0, 1, 0, 1, 1};
    tbl[6]  = '{68,  0,  2, 0, 1, 0, 1, 0, 1, 1};
    tbl[7]  = '{150, 7,  4, 1, 1, 1, 0, 0, 1, 1};
    tbl[8]  = '{151, 7,  4, 1, 1, 1, 0, 0, 0, 1};
    tbl[9]  = '{164, 14, 4, 1, 1, 1, 0, 0, 1, 1};
    tbl[10] = '{166, 15, 4, 1, 1, 0, 0, 0, 1, 1};
    tbl[11] = '{266, 14, 7, 1, 1, 1, 0, 0, 1, 1};
    tbl[12] = '{268, 15, 7, 1, 1, 0, 0, 0, 1, 1};
    tbl[13] = '{304, 16, 8, 1, 1, 0, 0, 0, 1, 1};
    tbl[14] = '{306, 0,  0, 0, 0, 0, 1, 1, 1, 1};
    tbl[15] = '{307, 0,  0, 0, 0, 0, 0, 0, 0, 1};

    rst = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    chk_vec("reset", pk(0, 0, 1, 1, 0, 0, 0, 0, 0));

    rst = 1'b0;
    mon_en = 1'b1;
    idx = 0;
    ls_n = 0; ls_last = -1; ls_bad = 0; fs_n = 0;
    act_n = 0; hs_low = 0; vs_low = 0; pt_n = 0;
    max_h = 0; max_v = 0;
    for (int c = 0; c < 308; c++) begin
      step();
      if (idx < NV && tbl[idx].c == c) begin
        chk_vec($sformatf("vec_c%0d", c),
                pk(tbl[idx].h, tbl[idx].v, tbl[idx].hs, tbl[idx].vs,
                   tbl[idx].act, tbl[idx].ls, tbl[idx].fs,
                   tbl[idx].pt, tbl[idx].run));
        idx++;
      end
      if (line_start) begin
        ls_n++;
        if (ls_last >= 0 && c - ls_last != HT * CD) ls_bad++;
        ls_last = c;
      end
      if (frame_start) fs_n++;
      if (active && pixel_tick) act_n++;
      if (c < HT * CD && !hsync) hs_low++;
      if (c < HT * VT * CD && !vsync) vs_low++;
      if (pixel_tick) pt_n++;
      if (int'(countH) > max_h) max_h = int'(countH);
      if (int'(countV) > max_v) max_v = int'(countV);
    end
    chk("line_start_count", ls_n, 10);
    chk("line_period_bad", ls_bad, 0);
    chk("frame_start_count", fs_n, 2);
    chk("active_ticks", act_n, 32);
    chk("hsync_low_clks", hs_low, 8);
    chk("vsync_low_clks", vs_low, 68);
    chk("pixel_ticks", pt_n, 153);
    chk("max_countH", max_h, HT - 1);
    chk("max_countV", max_v, VT - 1);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = (countV == 10'd2);
    end
    if (!found) timeout("wait_v2");
    enable = 1'b0;
    n = 0; lh = 0; lv = 0;
    found = 1'b0;
    while (!found && n < 400) begin
      lh = int'(countH);
      lv = int'(countV);
      step();
      n++;
      found = !running;
    end
    if (!found) timeout("drain_idle");
    chk("drain_cycles", n, 238);
    chk("drain_last_h", lh, HT - 1);
    chk("drain_last_v", lv, VT - 1);
    chk_vec("drain_idle", pk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    repeat (5) step();
    chk_vec("idle_hold", pk(0, 0, 1, 1, 0, 0, 0, 0, 0));

    enable = 1'b1;
    step();
    chk_vec("restart", pk(0, 0, 0, 0, 0, 1, 1, 0, 1));
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = (countV == 10'd2);
    end
    if (!found) timeout("wait_v2b");
    enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      found = (countV == 10'd5);
    end
    if (!found) timeout("wait_v5");
    chk("drain_running", int'(running), 1);
    enable = 1'b1;
    idle_seen = 0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (!running) idle_seen++;
      found = frame_start;
    end
    if (!found) timeout("rerun_wrap");
    chk("rerun_no_idle", idle_seen, 0);
    chk_vec("rerun_wrap", pk(0, 0, 0, 0, 0, 1, 1, 1, 1));

    enable = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      found = (countH == 10'd16) && (countV == 10'd8) && !pixel_tick;
    end
    if (!found) timeout("wait_eof");
    enable = 1'b1;
    step();
    chk_vec("eof_enable", pk(0, 0, 0, 0, 0, 1, 1, 1, 1));

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      found = (countH == 10'd10) && !pixel_tick;
    end
    if (!found) timeout("wait_h10");
    rst = 1'b1;
    step();
    chk_vec("mid_reset", pk(0, 0, 1, 1, 0, 0, 0, 0, 0));
    rst = 1'b0;
    step();
    chk_vec("post_reset", pk(0, 0, 0, 0, 0, 1, 1, 0, 1));
    step();
    step();
    chk_vec("post_reset_c2", pk(1, 0, 0, 0, 0, 0, 0, 1, 1));

    chk("continuity_bad", cont_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Sequences the 640x480 VGA raster by generating the countH/countV counters consumed by comparator_display, together with hsync/vsync, a pixel-rate tick and line/frame strobes.
- Divides the system clock down to the pixel rate.
- Runs or stops only on frame boundaries, under an enable request with a status handshake.
- Sits between the system clock domain and the display comparator and pixel generator.

Parameters:
N, 9, counter MSB index; counters are N+1 bits and must hold H_TOTAL-1
CLK_DIV, 2, system clocks per pixel (>=1)
H_SYNC, 96, hsync pulse width in pixels
H_BACK, 46, horizontal back porch
H_ACTIVE, 640, visible pixels per line
H_FRONT, 18, horizontal front porch
V_SYNC, 2, vsync width in lines
V_BACK, 33, vertical back porch
V_ACTIVE, 480, visible lines
V_FRONT, 10, vertical front porch

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
enable  input  1  run request; level-sensitive
countH  output  N+1  horizontal pixel counter, 0..H_TOTAL-1
countV  output  N+1  vertical line counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
pixel_tick  output  1  one-clk strobe on each cycle that the counters advance
active  output  1  high while countH/countV are inside the visible window
line_start  output  1  one-clk pulse when countH becomes 0
frame_start  output  1  one-clk pulse when countH and countV both become 0
running  output  1  high in RUN and DRAIN states

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Derived timing: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Active window: countH in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] = [142,781]; countV in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1] = [35,514].
- Reset state: IDLE. countH=countV=0, divider=0, hsync=vsync=1, active=pixel_tick=line_start=frame_start=running=0.
- Registered outputs: every output is a register. hsync, vsync and active are computed from the next counter values, so they are aligned with countH/countV in the same cycle.
- Divider: div_cnt counts 0..CLK_DIV-1 in RUN/DRAIN and is held at 0 in IDLE. A tick occurs when div_cnt==CLK_DIV-1; with CLK_DIV=1, every cycle ticks. pixel_tick is high during the cycle in which the counters have just advanced.
- Counter update on each tick:
  - countH wraps from H_TOTAL-1 to 0.
  - countV increments only when countH wraps.
  - countV wraps from V_TOTAL-1 to 0.
  - No other values are ever output.
- Sync levels: hsync=0 iff countH<H_SYNC; vsync=0 iff countV<V_SYNC.
- Strobes:
  - line_start=1 for exactly one clk when countH becomes 0.
  - frame_start=1 for exactly one clk when the frame wraps.
  - Both strobes also pulse on the first RUN cycle after IDLE.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE, enable=1 -> RUN next cycle. Counters start at 0,0; line_start and frame_start pulse.
  - RUN, enable=0 -> DRAIN. Counting continues uninterrupted.
  - DRAIN, enable=1 -> RUN. No gap and no counter disturbance.
  - DRAIN, the tick at countH=H_TOTAL-1 and countV=V_TOTAL-1 -> IDLE. Counters go to 0, hsync/vsync go to 1, running goes to 0.
  - RUN, end-of-frame tick -> stay in RUN and wrap.
- Simultaneous events: if enable rises on the same cycle DRAIN reaches end of frame, the FSM goes to RUN, not IDLE. A frame never stops mid-frame without a reset.
- Reset mid-operation: the next cycle shows full reset values, regardless of state or divider phase.
- Output stability: outputs change only on tick cycles or on state transitions; they do not glitch between ticks.

Test Plan:
- Reset: hold rst 3 clks with enable=1 -> countH=countV=0, hsync=vsync=1, running=0. Release -> running=1 and frame_start=1 in the first RUN cycle.
- Line timing, CLK_DIV=2: line_start period = 1600 clks; hsync low for 192 clks starting at countH=0; pixel_tick high every 2nd clk.
- Frame timing: frame_start period = 840000 clks. vsync low for exactly 2 lines (countV 0..1). countV never exceeds 524; countH never exceeds 799.
- Active window: active rises on the tick where (countH,countV)=(142,35) and falls on the tick after (781,514). Total active ticks per frame = 307200.
- Drain: drop enable at countV=200 -> counting continues to (799,524), then IDLE with counters 0 and running=0. Re-raise enable at countV=300 during DRAIN -> state returns to RUN with counters unbroken.
- Reset mid-line at countH=400, div_cnt=1 -> next cycle all outputs at reset values. With enable=1, counting restarts cleanly from 0.
